mux_sel_sequencer: RTL and testbench

//  Upstream controller for the 4-bit, 4:1 source-select mux stage.

---
 rtl/mux_sel_sequencer_if.sv | 22 ++
 rtl/mux_sel_sequencer.sv | 105 ++++++++++
 tb/tb_mux_sel_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_sequencer_if.sv
// Handshake bundle between the select-sequencer and whatever controls it.
// master = controller side (drives en/auto_mode/step), slave = sequencer side.
interface mux_sel_sequencer_if #(
  parameter int CW = 4
);
  logic          en;
  logic          auto_mode;
  logic          step;
  logic [1:0]    sel;
  logic [CW-1:0] count_o;
  logic          frame_done;

  modport master (
    output en, auto_mode, step,
    input  sel, count_o, frame_done
  );

  modport slave (
    input  en, auto_mode, step,
    output sel, count_o, frame_done
  );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Select/count sequencer for the 4:1 source mux (count, K, F, zero).
// Optional macro SEQ_SKIP_BLANK_EN drops the S_BLANK state from the frame.
module mux_sel_sequencer #(
  parameter int CW    = 4,
  parameter int DWELL = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  mux_sel_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_CNT   = 2'b00,
    S_K     = 2'b01,
    S_F     = 2'b10,
    S_BLANK = 2'b11
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

`ifdef SEQ_SKIP_BLANK_EN
  localparam state_t S_LAST = S_F;
`else
  localparam state_t S_LAST = S_BLANK;
`endif

  state_t        state_q, state_d;
  logic [7:0]    dwell_q, dwell_d;
  logic          step_q;
  logic [CW-1:0] count_q, count_d;
  logic          frame_done_q, frame_done_d;
  logic          adv;
  logic          wrap;

  // Advance event: dwell expiry in auto mode, rising step edge in manual mode.
  always_comb begin
    adv = 1'b0;
    if (bus.auto_mode) begin
      adv = bus.en & (dwell_q == DWELL_LAST);
    end else begin
      adv = bus.en & bus.step & ~step_q;
    end
  end

  assign wrap = adv & (state_q == S_LAST);

  always_comb begin
    state_d = state_q;
    if (adv) begin
      unique case (state_q)
        S_CNT:   state_d = S_K;
        S_K:     state_d = S_F;
`ifdef SEQ_SKIP_BLANK_EN
        S_F:     state_d = S_CNT;
`else
        S_F:     state_d = S_BLANK;
`endif
        S_BLANK: state_d = S_CNT;
        default: state_d = S_CNT;
      endcase
    end
  end

  // Manual mode keeps the dwell counter parked at 0 so a mode switch restarts it.
  always_comb begin
    dwell_d = dwell_q;
    if (!bus.auto_mode) begin
      dwell_d = 8'd0;
    end else if (adv) begin
      dwell_d = 8'd0;
    end else if (bus.en) begin
      dwell_d = dwell_q + 8'd1;
    end
  end

  always_comb begin
    count_d      = count_q;
    frame_done_d = 1'b0;
    if (wrap) begin
      count_d      = count_q + CW'(1);
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CNT;
      dwell_q      <= 8'd0;
      step_q       <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      step_q       <= bus.step;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.sel        = state_q;
  assign bus.count_o    = count_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench: two sequencers (DWELL=3 and DWELL=1) driven in lockstep,
// each checked against a cycle model plus fixed reference sequences.
module tb_mux_sel_sequencer;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] cnt;
    logic       fd;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.CW(4)) if0 ();
  mux_sel_sequencer_if #(.CW(4)) if1 ();

  mux_sel_sequencer #(.CW(4), .DWELL(3)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  mux_sel_sequencer #(.CW(4), .DWELL(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

`ifdef SEQ_SKIP_BLANK_EN
  localparam int FRAME0 = 9;
`else
  localparam int FRAME0 = 12;
`endif

  // reference model state, index 0 -> DWELL=3, index 1 -> DWELL=1
  logic [1:0] m_state [2] = '{2'd0, 2'd0};
  int         m_dwell [2] = '{0, 0};
  logic       m_stepq [2] = '{1'b0, 1'b0};
  logic [3:0] m_count [2] = '{4'd0, 4'd0};
  logic       m_fd    [2] = '{1'b0, 1'b0};

  obs_t q0[$];
  obs_t q1[$];
  obs_t e0, e1, o0, o1;

  task automatic model_clk(input int k, input logic r, input logic e, input logic a, input logic s);
    int         dw;
    logic       adv;
    logic [1:0] last;
    dw = (k == 0) ? 3 : 1;
`ifdef SEQ_SKIP_BLANK_EN
    last = 2'd2;
`else
    last = 2'd3;
`endif
    if (r) begin
      m_state[k] = 2'd0; m_dwell[k] = 0; m_stepq[k] = 1'b0;
      m_count[k] = 4'd0; m_fd[k] = 1'b0;
    end else begin
      adv = a ? (e && (m_dwell[k] == dw - 1)) : (e && s && !m_stepq[k]);
      m_fd[k] = adv && (m_state[k] == last);
      if (m_fd[k]) m_count[k] = m_count[k] + 4'd1;
      if (adv) m_state[k] = (m_state[k] == last) ? 2'd0 : m_state[k] + 2'd1;
      if (!a) m_dwell[k] = 0;
      else if (adv) m_dwell[k] = 0;
      else if (e) m_dwell[k] = m_dwell[k] + 1;
      m_stepq[k] = s;
    end
  endtask

  // Drive one cycle of inputs, push the model's prediction, advance past the edge.
  task automatic tick(input logic r, input logic e, input logic a, input logic s);
    reset = r;
    if0.en = e; if0.auto_mode = a; if0.step = s;
    if1.en = e; if1.auto_mode = a; if1.step = s;
    model_clk(0, r, e, a, s);
    model_clk(1, r, e, a, s);
    q0.push_back('{m_state[0], m_count[0], m_fd[0]});
    q1.push_back('{m_state[1], m_count[1], m_fd[1]});
    @(posedge clk);
    #1;
    e0 = q0.pop_front(); e1 = q1.pop_front();
    o0 = '{if0.sel, if0.count_o, if0.frame_done};
    o1 = '{if1.sel, if1.count_o, if1.frame_done};
  endtask

  task automatic test_reset(input string name);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL %s dut0 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", name, i, o0.sel, o0.cnt, o0.fd, e0.sel, e0.cnt, e0.fd); end
      if (o1 !== e1) begin errors++; $display("FAIL %s dut1 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", name, i, o1.sel, o1.cnt, o1.fd, e1.sel, e1.cnt, e1.fd); end
      checks++;
      if (o0 !== 7'b00_0000_0) begin errors++; $display("FAIL %s_const cyc%0d: got sel=%0d cnt=%0d fd=%b expected all zero", name, i, o0.sel, o0.cnt, o0.fd); end
    end
  endtask

  task automatic test_auto_frame();
    logic [1:0] ref_sel [12];
    int         fd_at;
`ifdef SEQ_SKIP_BLANK_EN
    ref_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1};
    fd_at = 8;
`else
    ref_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    fd_at = 11;
`endif
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL auto_frame dut0 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o0.sel, o0.cnt, o0.fd, e0.sel, e0.cnt, e0.fd); end
      if (o1 !== e1) begin errors++; $display("FAIL auto_frame dut1 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o1.sel, o1.cnt, o1.fd, e1.sel, e1.cnt, e1.fd); end
      checks++;
      if (o0.sel !== ref_sel[i] || o0.fd !== (i == fd_at) || o0.cnt !== ((i >= fd_at) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL auto_frame_ref cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d fd=%b", i, o0.sel, o0.cnt, o0.fd, ref_sel[i], (i == fd_at));
      end
    end
  endtask

  task automatic test_manual_step();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      // step high 5 cycles, low 4, then one fresh rising edge
      tick(1'b0, 1'b1, 1'b0, (i < 5 || i == 9));
      checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL manual dut0 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o0.sel, o0.cnt, o0.fd, e0.sel, e0.cnt, e0.fd); end
      if (o1 !== e1) begin errors++; $display("FAIL manual dut1 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o1.sel, o1.cnt, o1.fd, e1.sel, e1.cnt, e1.fd); end
      checks += 2;
      if (o0.sel !== ((i == 9) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL manual_ref dut0 cyc%0d: got sel=%0d expected %0d", i, o0.sel, (i == 9) ? 2 : 1); end
      if (o1.sel !== ((i == 9) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL manual_ref dut1 cyc%0d: got sel=%0d expected %0d", i, o1.sel, (i == 9) ? 2 : 1); end
    end
  endtask

  task automatic test_count_wrap();
    int pulses = 0;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16 * FRAME0; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL wrap dut0 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o0.sel, o0.cnt, o0.fd, e0.sel, e0.cnt, e0.fd); end
      if (o1 !== e1) begin errors++; $display("FAIL wrap dut1 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o1.sel, o1.cnt, o1.fd, e1.sel, e1.cnt, e1.fd); end
      if (i == 15 * FRAME0 - 1) begin
        checks++;
        if (o0.cnt !== 4'hF) begin errors++; $display("FAIL wrap_preload: got cnt=%h expected F", o0.cnt); end
      end
      if (i >= 15 * FRAME0 && o0.fd === 1'b1) pulses++;
    end
    checks += 2;
    if (o0.cnt !== 4'h0) begin errors++; $display("FAIL wrap_zero: got cnt=%h expected 0", o0.cnt); end
    if (pulses != 1) begin errors++; $display("FAIL wrap_pulses: got %0d frame_done pulses expected 1", pulses); end
  endtask

  task automatic test_en_freeze();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, (i >= 4), 1'b1, (i == 1));
      checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL en_freeze dut0 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o0.sel, o0.cnt, o0.fd, e0.sel, e0.cnt, e0.fd); end
      if (o1 !== e1) begin errors++; $display("FAIL en_freeze dut1 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o1.sel, o1.cnt, o1.fd, e1.sel, e1.cnt, e1.fd); end
      checks++;
      if (o0.sel !== ((i == 5) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL en_freeze_ref cyc%0d: got sel=%0d expected %0d", i, o0.sel, (i == 5) ? 1 : 0); end
    end
  endtask

  task automatic test_mode_switch();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      // two auto cycles, one manual cycle (clears dwell), then auto again
      tick(1'b0, 1'b1, (i != 2), 1'b0);
      checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL mode_switch dut0 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o0.sel, o0.cnt, o0.fd, e0.sel, e0.cnt, e0.fd); end
      if (o1 !== e1) begin errors++; $display("FAIL mode_switch dut1 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o1.sel, o1.cnt, o1.fd, e1.sel, e1.cnt, e1.fd); end
      checks++;
      if (o0.sel !== ((i >= 5) ? 2'd1 : 2'd0)) begin errors++; $display("FAIL mode_switch_ref cyc%0d: got sel=%0d expected %0d", i, o0.sel, (i >= 5) ? 1 : 0); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           (($urandom_range(0, 15) != 0) ? if0.auto_mode : ~if0.auto_mode),
           $urandom_range(0, 1));
      checks += 2;
      if (o0 !== e0) begin errors++; $display("FAIL random dut0 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o0.sel, o0.cnt, o0.fd, e0.sel, e0.cnt, e0.fd); end
      if (o1 !== e1) begin errors++; $display("FAIL random dut1 cyc%0d: got sel=%0d cnt=%0d fd=%b expected sel=%0d cnt=%0d fd=%b", i, o1.sel, o1.cnt, o1.fd, e1.sel, e1.cnt, e1.fd); end
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    test_reset("reset_midframe");
  endtask

  initial begin
    reset = 1'b1;
    if0.en = 1'b0; if0.auto_mode = 1'b1; if0.step = 1'b0;
    if1.en = 1'b0; if1.auto_mode = 1'b1; if1.step = 1'b0;
    test_reset("reset");
    test_auto_frame();
    test_manual_step();
    test_count_wrap();
    test_en_freeze();
    test_mode_switch();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
